wt_dcache_shct: RTL and testbench

Parametrised signature history counter table (SHCT) for the write-through L1 dcache's SHiP-style replacement. It holds one saturating reuse counter per signature, answers registered lookups for the fill path, and folds in one hit update plus up to NumWays eviction updates per cycle. Several updates to the same signature in one cycle are merged into one net change. A flush walks the table with a sweep state machine. It sits between the dcache controller (hit/evict/fill events) and the replacement logic, which consumes the result.

---
 rtl/wt_dcache_shct.sv | 194 +++++++++++++++++++
 tb/tb_wt_dcache_shct.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wt_dcache_shct.sv
`default_nettype none
// ============================================================================
// Module      : wt_dcache_shct
// Description : Signature history counter table for SHiP-style replacement in
//               the write-through L1 dcache. One saturating reuse counter per
//               signature, registered lookups for the fill path, merged
//               hit/eviction updates, and a block-wise flush sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module wt_dcache_shct #(
    parameter int unsigned SigWidth      = 14,
    parameter int unsigned CtrWidth      = 2,
    parameter int unsigned NumWays       = 4,
    parameter int unsigned ResetValue    = 2**CtrWidth - 1,
    parameter int unsigned ClearPerCycle = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               flush_i,
    output logic                               busy_o,
    input  logic                               lookup_valid_i,
    input  logic [SigWidth-1:0]                lookup_sig_i,
    output logic                               lookup_ready_o,
    output logic                               result_valid_o,
    output logic [CtrWidth-1:0]                result_ctr_o,
    output logic                               result_reuse_o,
    input  logic                               hit_valid_i,
    input  logic [SigWidth-1:0]                hit_sig_i,
    input  logic [NumWays-1:0]                 evict_valid_i,
    input  logic [NumWays-1:0][SigWidth-1:0]   evict_sig_i,
    input  logic [NumWays-1:0]                 evict_reused_i
);

    localparam int unsigned c_depth  = 2**SigWidth;
    localparam int unsigned c_nports = NumWays + 1;
    // Signed width large enough for old value plus a delta down to -NumWays.
    localparam int unsigned c_sw     = CtrWidth + $clog2(NumWays + 1) + 2;

    localparam logic [CtrWidth-1:0] c_ctr_max    = '1;
    localparam logic [CtrWidth-1:0] c_reset_val  = CtrWidth'(ResetValue);
    localparam logic [SigWidth-1:0] c_clear_step = SigWidth'(ClearPerCycle);
    localparam logic [SigWidth-1:0] c_last_idx   = SigWidth'(c_depth - ClearPerCycle);

    localparam logic signed [c_sw-1:0] c_plus_one  = c_sw'(1);
    localparam logic signed [c_sw-1:0] c_minus_one = '1;
    localparam logic signed [c_sw-1:0] c_max_s     = c_sw'(c_ctr_max);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_sweep = 1'b1;

    logic [CtrWidth-1:0] r_table [c_depth];

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [SigWidth-1:0] r_idx;
    logic [SigWidth-1:0] w_idx_next;

    logic                r_result_valid;
    logic [CtrWidth-1:0] r_result_ctr;
    logic                w_lookup_acc;

    // Update ports: index 0 is the hit port, 1..NumWays are the eviction ways.
    logic [c_nports-1:0][SigWidth-1:0] w_port_sig;
    logic [c_nports-1:0]               w_port_act;
    logic [c_nports-1:0]               w_port_inc;

    logic signed [c_sw-1:0]  w_delta [c_nports];
    logic signed [c_sw-1:0]  w_sum   [c_nports];
    logic [CtrWidth-1:0]     w_new   [c_nports];
    logic [c_nports-1:0]     w_first;

    assign w_port_sig[0] = hit_sig_i;
    assign w_port_act[0] = hit_valid_i;
    assign w_port_inc[0] = 1'b1;

    generate
        for (genvar w = 0; w < int'(NumWays); w++) begin : g_evict_port
            // Reused evictions contribute nothing, so they are not active ports.
            assign w_port_sig[w+1] = evict_sig_i[w];
            assign w_port_act[w+1] = evict_valid_i[w] && !evict_reused_i[w];
            assign w_port_inc[w+1] = 1'b0;
        end
    endgenerate

    // Merge all contributions per signature; the lowest active port owns the write.
    always_comb begin
        for (int p = 0; p < int'(c_nports); p++) begin
            w_delta[p] = '0;
            w_first[p] = w_port_act[p];
            for (int q = 0; q < int'(c_nports); q++) begin
                if (w_port_act[q] && (w_port_sig[q] == w_port_sig[p])) begin
                    w_delta[p] = w_delta[p] + (w_port_inc[q] ? c_plus_one : c_minus_one);
                    if (q < p) begin
                        w_first[p] = 1'b0;
                    end
                end
            end
            w_sum[p] = c_sw'(r_table[w_port_sig[p]]) + w_delta[p];
            if (w_sum[p] < 0) begin
                w_new[p] = '0;
            end else if (w_sum[p] > c_max_s) begin
                w_new[p] = c_ctr_max;
            end else begin
                w_new[p] = w_sum[p][CtrWidth-1:0];
            end
        end
    end

    // Sweep FSM state and index register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_st_idle;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // Sweep FSM next-state: a flush always (re)starts the walk at index 0.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            c_st_idle: begin
                if (flush_i) begin
                    w_state_next = c_st_sweep;
                    w_idx_next   = '0;
                end
            end
            c_st_sweep: begin
                if (flush_i) begin
                    w_state_next = c_st_sweep;
                    w_idx_next   = '0;
                end else if (r_idx == c_last_idx) begin
                    w_state_next = c_st_idle;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next   = r_idx + c_clear_step;
                end
            end
            default: begin
                w_state_next = c_st_idle;
                w_idx_next   = '0;
            end
        endcase
    end

    // Sweep FSM outputs.
    always_comb begin
        busy_o = (r_state == c_st_sweep);
    end

    assign lookup_ready_o = !busy_o && !rst_i;
    assign w_lookup_acc   = lookup_valid_i && lookup_ready_o;

    // Table storage: reset fill, sweep block clear, or merged updates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(c_depth); i++) begin
                r_table[SigWidth'(i)] <= c_reset_val;
            end
        end else if (r_state == c_st_sweep) begin
            for (int c = 0; c < int'(ClearPerCycle); c++) begin
                r_table[r_idx + SigWidth'(c)] <= c_reset_val;
            end
        end else if (!flush_i) begin
            for (int p = 0; p < int'(c_nports); p++) begin
                if (w_first[p]) begin
                    r_table[w_port_sig[p]] <= w_new[p];
                end
            end
        end
    end

    // Registered lookup result; the counter holds its value between lookups.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_result_valid <= 1'b0;
            r_result_ctr   <= '0;
        end else begin
            r_result_valid <= w_lookup_acc;
            if (w_lookup_acc) begin
                r_result_ctr <= r_table[lookup_sig_i];
            end
        end
    end

    assign result_valid_o = r_result_valid;
    assign result_ctr_o   = r_result_ctr;
    assign result_reuse_o = |r_result_ctr;

endmodule
`default_nettype wire

// File: tb/tb_wt_dcache_shct.sv
`default_nettype none
// ============================================================================
// Module      : tb_wt_dcache_shct
// Description : Self-checking bench for wt_dcache_shct: table of single-cycle
//               vectors plus hand-written flush, restart and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wt_dcache_shct;

    logic              clk_i;
    logic              rst_i;
    logic              flush_i;
    logic              busy_o;
    logic              lookup_valid_i;
    logic [13:0]       lookup_sig_i;
    logic              lookup_ready_o;
    logic              result_valid_o;
    logic [1:0]        result_ctr_o;
    logic              result_reuse_o;
    logic              hit_valid_i;
    logic [13:0]       hit_sig_i;
    logic [3:0]        evict_valid_i;
    logic [3:0][13:0]  evict_sig_i;
    logic [3:0]        evict_reused_i;

    int n_chk  = 0;
    int n_fail = 0;

    wt_dcache_shct dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .busy_o         (busy_o),
        .lookup_valid_i (lookup_valid_i),
        .lookup_sig_i   (lookup_sig_i),
        .lookup_ready_o (lookup_ready_o),
        .result_valid_o (result_valid_o),
        .result_ctr_o   (result_ctr_o),
        .result_reuse_o (result_reuse_o),
        .hit_valid_i    (hit_valid_i),
        .hit_sig_i      (hit_sig_i),
        .evict_valid_i  (evict_valid_i),
        .evict_sig_i    (evict_sig_i),
        .evict_reused_i (evict_reused_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic             hv;
        logic [13:0]      hs;
        logic [3:0]       ev;
        logic [3:0]       er;
        logic [3:0][13:0] es;
        logic             lv;
        logic [13:0]      ls;
        logic [1:0]       exp_ctr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic hv, input logic [13:0] hs,
                       input logic [3:0] ev, input logic [3:0] er,
                       input logic [13:0] s0, input logic [13:0] s1,
                       input logic [13:0] s2, input logic [13:0] s3,
                       input logic lv, input logic [13:0] ls, input logic [1:0] e);
        vec_t v;
        v.hv = hv; v.hs = hs; v.ev = ev; v.er = er;
        v.es = {s3, s2, s1, s0};
        v.lv = lv; v.ls = ls; v.exp_ctr = e;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_in();
        flush_i        = 1'b0;
        lookup_valid_i = 1'b0;
        lookup_sig_i   = '0;
        hit_valid_i    = 1'b0;
        hit_sig_i      = '0;
        evict_valid_i  = '0;
        evict_sig_i    = '0;
        evict_reused_i = '0;
    endtask

    task automatic lookup(input logic [13:0] sig, input logic [1:0] e, input string nm);
        idle_in();
        lookup_valid_i = 1'b1;
        lookup_sig_i   = sig;
        cyc();
        idle_in();
        chk({nm, "_valid"}, result_valid_o, 1'b1);
        chk({nm, "_ctr"}, result_ctr_o, e);
        chk({nm, "_reuse"}, result_reuse_o, (e != 0));
    endtask

    task automatic evict_all(input logic [13:0] sig, input logic [3:0] ways);
        idle_in();
        evict_valid_i = ways;
        evict_sig_i   = {sig, sig, sig, sig};
        cyc();
        idle_in();
    endtask

    initial begin
        logic [1:0] last_ctr;
        int cnt;
        int cnt2;
        int ready_bad;
        int acc_bad;

        // Reset with lookup and flush requested: both ignored.
        idle_in();
        rst_i          = 1'b1;
        flush_i        = 1'b1;
        lookup_valid_i = 1'b1;
        lookup_sig_i   = 14'h0123;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_ready", lookup_ready_o, 1'b0);
            chk("rst_busy", busy_o, 1'b0);
            chk("rst_rvalid", result_valid_o, 1'b0);
        end
        rst_i = 1'b0;
        idle_in();
        cyc();
        chk("post_rst_busy", busy_o, 1'b0);
        chk("post_rst_rvalid", result_valid_o, 1'b0);
        chk("post_rst_ctr", result_ctr_o, 2'd0);
        chk("post_rst_reuse", result_reuse_o, 1'b0);
        chk("post_rst_ready", lookup_ready_o, 1'b1);

        // Directed single-cycle vectors (lookup result reflects pre-update value).
        add(0, 14'h0000, 4'h0, 4'h0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1, 14'h0123, 2'd3);
        add(0, 14'h0000, 4'hF, 4'h0, 14'h0010, 14'h0010, 14'h0010, 14'h0010, 0, 14'h0000, 2'd0);
        add(0, 14'h0000, 4'h0, 4'h0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1, 14'h0010, 2'd0);
        add(0, 14'h0000, 4'h1, 4'h0, 14'h0010, 14'h0000, 14'h0000, 14'h0000, 1, 14'h0010, 2'd0);
        add(0, 14'h0000, 4'h0, 4'h0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1, 14'h0010, 2'd0);
        add(0, 14'h0000, 4'h1, 4'h0, 14'h0020, 14'h0000, 14'h0000, 14'h0000, 0, 14'h0000, 2'd0);
        add(1, 14'h0020, 4'h4, 4'h0, 14'h0000, 14'h0000, 14'h0020, 14'h0000, 1, 14'h0020, 2'd2);
        add(0, 14'h0000, 4'h0, 4'h0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1, 14'h0020, 2'd2);
        add(0, 14'h0000, 4'h3, 4'h0, 14'h3FFF, 14'h3FFF, 14'h0000, 14'h0000, 1, 14'h3FFF, 2'd3);
        add(1, 14'h3FFF, 4'h0, 4'h0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1, 14'h3FFF, 2'd1);
        add(1, 14'h3FFF, 4'h0, 4'h0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1, 14'h3FFF, 2'd2);
        add(1, 14'h3FFF, 4'h0, 4'h0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1, 14'h3FFF, 2'd3);
        add(0, 14'h0000, 4'h8, 4'h8, 14'h0000, 14'h0000, 14'h0000, 14'h3FFF, 1, 14'h3FFF, 2'd3);
        add(0, 14'h0000, 4'h0, 4'h0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1, 14'h3FFF, 2'd3);
        add(0, 14'h0050, 4'h0, 4'h0, 14'h0050, 14'h0050, 14'h0000, 14'h0000, 1, 14'h0050, 2'd3);
        add(0, 14'h0000, 4'h0, 4'h0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1, 14'h0050, 2'd3);
        add(1, 14'h0060, 4'hA, 4'h0, 14'h0000, 14'h0061, 14'h0000, 14'h0060, 0, 14'h0000, 2'd0);
        add(0, 14'h0000, 4'h0, 4'h0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1, 14'h0060, 2'd3);
        add(0, 14'h0000, 4'h0, 4'h0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1, 14'h0061, 2'd2);
        add(0, 14'h0070, 4'h7, 4'h2, 14'h0070, 14'h0071, 14'h0071, 14'h0000, 0, 14'h0000, 2'd0);
        add(0, 14'h0000, 4'h0, 4'h0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1, 14'h0070, 2'd2);
        add(0, 14'h0000, 4'h0, 4'h0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1, 14'h0071, 2'd2);
        add(0, 14'h0000, 4'hF, 4'h5, 14'h0100, 14'h0101, 14'h0102, 14'h0103, 0, 14'h0000, 2'd0);
        add(0, 14'h0000, 4'h0, 4'h0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1, 14'h0100, 2'd3);
        add(0, 14'h0000, 4'h0, 4'h0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1, 14'h0101, 2'd2);
        add(0, 14'h0000, 4'h0, 4'h0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1, 14'h0102, 2'd3);
        add(0, 14'h0000, 4'h0, 4'h0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1, 14'h0103, 2'd2);

        last_ctr = 2'd0;
        for (int i = 0; i < vq.size(); i++) begin
            idle_in();
            hit_valid_i    = vq[i].hv;
            hit_sig_i      = vq[i].hs;
            evict_valid_i  = vq[i].ev;
            evict_reused_i = vq[i].er;
            evict_sig_i    = vq[i].es;
            lookup_valid_i = vq[i].lv;
            lookup_sig_i   = vq[i].ls;
            cyc();
            chk($sformatf("vec%0d_valid", i), result_valid_o, vq[i].lv);
            if (vq[i].lv) begin
                last_ctr = vq[i].exp_ctr;
                chk($sformatf("vec%0d_reuse", i), result_reuse_o, (vq[i].exp_ctr != 0));
            end
            chk($sformatf("vec%0d_ctr", i), result_ctr_o, last_ctr);
        end
        idle_in();

        // Flush sweep: pre-flush lookup, dropped updates, exact busy length.
        evict_all(14'h0040, 4'h7);
        lookup(14'h0040, 2'd0, "f_pre");
        flush_i        = 1'b1;
        lookup_valid_i = 1'b1;
        lookup_sig_i   = 14'h0040;
        cyc();
        idle_in();
        chk("f_flushcyc_valid", result_valid_o, 1'b1);
        chk("f_flushcyc_ctr", result_ctr_o, 2'd0);
        chk("f_busy_rise", busy_o, 1'b1);
        cnt = 0; ready_bad = 0; acc_bad = 0;
        while (busy_o === 1'b1 && cnt < 3000) begin
            idle_in();
            if (cnt == 5) begin
                hit_valid_i   = 1'b1;
                hit_sig_i     = 14'h0040;
                evict_valid_i = 4'h1;
                evict_sig_i   = {14'h0, 14'h0, 14'h0, 14'h0005};
            end
            lookup_valid_i = 1'b1;
            lookup_sig_i   = 14'h0123;
            if (lookup_ready_o !== 1'b0) ready_bad++;
            cyc();
            cnt++;
            if (result_valid_o !== 1'b0) acc_bad++;
        end
        idle_in();
        chk("f_busy_len", cnt, 1024);
        chk("f_ready_low", ready_bad, 0);
        chk("f_no_accept", acc_bad, 0);
        lookup(14'h0040, 2'd3, "f_post40");
        lookup(14'h0005, 2'd3, "f_post05");

        // Flush restart in sweep cycle 500.
        flush_i = 1'b1;
        cyc();
        idle_in();
        cnt = 0;
        while (busy_o === 1'b1 && cnt < 500) begin
            cyc();
            cnt++;
        end
        chk("r_reach500", cnt, 500);
        flush_i = 1'b1;
        cyc();
        idle_in();
        cnt2 = 0;
        while (busy_o === 1'b1 && cnt2 < 3000) begin
            cyc();
            cnt2++;
        end
        chk("r_busy_len", cnt2, 1024);

        // Reset in sweep cycle 10 with flush and update also presented.
        evict_all(14'h2000, 4'hF);
        lookup(14'h2000, 2'd0, "x_pre2000");
        lookup(14'h0123, 2'd3, "x_pre0123");
        flush_i = 1'b1;
        cyc();
        idle_in();
        cnt = 0;
        while (busy_o === 1'b1 && cnt < 10) begin
            cyc();
            cnt++;
        end
        chk("x_reach10", cnt, 10);
        rst_i          = 1'b1;
        flush_i        = 1'b1;
        evict_valid_i  = 4'hF;
        evict_sig_i    = {14'h0123, 14'h0123, 14'h0123, 14'h0123};
        lookup_valid_i = 1'b1;
        lookup_sig_i   = 14'h2000;
        chk("x_rst_ready", lookup_ready_o, 1'b0);
        cyc();
        rst_i = 1'b0;
        idle_in();
        chk("x_busy", busy_o, 1'b0);
        chk("x_rvalid", result_valid_o, 1'b0);
        chk("x_ctr", result_ctr_o, 2'd0);
        chk("x_reuse", result_reuse_o, 1'b0);
        cyc();
        chk("x_busy_stay", busy_o, 1'b0);
        lookup(14'h2000, 2'd3, "x_post2000");
        lookup(14'h0123, 2'd3, "x_post0123");
        lookup(14'h0010, 2'd3, "x_post0010");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
